dmem_handshake_ctrl: RTL and testbench

//  Data-memory slave directly downstream of the core's LD/ST port. Accepts one request at a time
//  on a valid/yumi handshake, performs a word or byte access on a local flop-array memory, and

---
 rtl/dmem_handshake_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_handshake_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_handshake_ctrl.sv
// Data-memory slave for one core's LD/ST port: valid/yumi request in, valid/yumi response out.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flag and suppress misaligned word accesses).
module dmem_handshake_ctrl #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 0
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        valid_i,
    input  logic        wen_i,
    input  logic        byte_not_word_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic        yumi_i,
    output logic        yumi_o,
    output logic        valid_o,
    output logic [31:0] read_data_o,
    output logic        busy_o,
    output logic        err_o
);

    // Handshake: a request transfers on a cycle with valid_i && yumi_o; a response
    // transfers on a cycle with valid_o && yumi_i. valid_i/valid_o are held until then.

    localparam int depth_lp = 1 << addr_width_p;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic [31:0]             mem [depth_lp];

    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             mem_word;
    logic [7:0]              lane_byte;
    logic [31:0]             resp_data;
    logic                    accept;
    logic                    misalign;
    logic                    do_write;
    logic                    unused_addr_bits;

    assign word_idx         = addr_i[2 +: addr_width_p];
    assign lane             = addr_i[1:0];
    assign unused_addr_bits = ^addr_i[31:addr_width_p+2];
    assign mem_word         = mem[word_idx];
    assign lane_byte        = mem_word[{lane, 3'b000} +: 8];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = !byte_not_word_i && (lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept   = (state_q == ST_IDLE) && valid_i && n_reset;
    assign yumi_o   = accept;
    assign do_write = accept && wen_i && !misalign;

    always_comb begin
        resp_data = '0;
        if (!wen_i && !misalign) begin
            resp_data = byte_not_word_i ? {24'b0, lane_byte} : mem_word;
        end
    end

    // Memory is deliberately not reset; a committed store survives a later reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (byte_not_word_i) begin
                mem[word_idx][{lane, 3'b000} +: 8] <= write_data_i[7:0];
            end else begin
                mem[word_idx] <= write_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            valid_o     <= 1'b0;
            read_data_o <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rdata_q <= resp_data;
                        err_q   <= misalign;
                        busy_o  <= 1'b1;
                        if (latency_p == 0) begin
                            state_q     <= ST_RESP;
                            valid_o     <= 1'b1;
                            read_data_o <= resp_data;
                            err_o       <= misalign;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(latency_p);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_q     <= ST_RESP;
                        valid_o     <= 1'b1;
                        read_data_o <= rdata_q;
                        err_o       <= err_q;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (yumi_i) begin
                        state_q     <= ST_IDLE;
                        valid_o     <= 1'b0;
                        read_data_o <= '0;
                        err_o       <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    a_resp_hold: assert property (@(posedge clk) disable iff (!n_reset)
        valid_o && !yumi_i |=> valid_o && $stable(read_data_o) && $stable(err_o));

    a_no_accept_busy: assert property (@(posedge clk) disable iff (!n_reset)
        busy_o |-> !yumi_o);

endmodule

// File: tb/tb_dmem_handshake_ctrl.sv
// Bench for dmem_handshake_ctrl: one instance at latency 0, one at latency 3, scoreboarded responses.
module tb_dmem_handshake_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       n_reset;
    logic [1:0]       valid_i;
    logic [1:0]       wen_i;
    logic [1:0]       byte_not_word_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] write_data_i;
    logic [1:0]       yumi_i;
    logic [1:0]       yumi_o;
    logic [1:0]       valid_o;
    logic [1:0][31:0] read_data_o;
    logic [1:0]       busy_o;
    logic [1:0]       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];

    dmem_handshake_ctrl #(.addr_width_p(10), .latency_p(0)) dut0 (
        .clk(clk), .n_reset(n_reset[0]), .valid_i(valid_i[0]), .wen_i(wen_i[0]),
        .byte_not_word_i(byte_not_word_i[0]), .addr_i(addr_i[0]),
        .write_data_i(write_data_i[0]), .yumi_i(yumi_i[0]), .yumi_o(yumi_o[0]),
        .valid_o(valid_o[0]), .read_data_o(read_data_o[0]), .busy_o(busy_o[0]),
        .err_o(err_o[0])
    );

    dmem_handshake_ctrl #(.addr_width_p(10), .latency_p(3)) dut1 (
        .clk(clk), .n_reset(n_reset[1]), .valid_i(valid_i[1]), .wen_i(wen_i[1]),
        .byte_not_word_i(byte_not_word_i[1]), .addr_i(addr_i[1]),
        .write_data_i(write_data_i[1]), .yumi_i(yumi_i[1]), .yumi_o(yumi_o[1]),
        .valid_o(valid_o[1]), .read_data_o(read_data_o[1]), .busy_o(busy_o[1]),
        .err_o(err_o[1])
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int d, input logic [32:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Monitors: every cycle a response is presented it must match the queue head;
    // the head is retired on the consuming cycle.
    always @(negedge clk) begin
        if (valid_o[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp0_unexpected: got %h, expected no response", read_data_o[0]);
            end else begin
                check("resp0", {err_o[0], read_data_o[0]}, exp_q0[0]);
                if (yumi_i[0]) void'(exp_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (valid_o[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp1_unexpected: got %h, expected no response", read_data_o[1]);
            end else begin
                check("resp1", {err_o[1], read_data_o[1]}, exp_q1[0]);
                if (yumi_i[1]) void'(exp_q1.pop_front());
            end
        end
    end

    // Drives one request; returns the number of cycles yumi_o took to appear.
    task automatic issue(input int d, input logic wen, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [32:0] e, input bit push,
                         output int waited);
        @(posedge clk);
        #1;
        if (push) push_exp(d, e);
        wen_i[d]           = wen;
        byte_not_word_i[d] = byt;
        addr_i[d]          = addr;
        write_data_i[d]    = wdata;
        valid_i[d]         = 1'b1;
        waited             = 0;
        forever begin
            @(negedge clk);
            if (yumi_o[d]) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: dut%0d got no yumi_o, expected within 50 cycles", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_i[d] = 1'b0;
    endtask

    // Waits for the response, checks its latency, holds yumi_i low, then consumes it.
    task automatic wait_resp(input int d, input int hold, input int exp_lat);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (valid_o[d]) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_timeout: dut%0d got no valid_o, expected within 50 cycles", d);
                return;
            end
        end
        check("resp_latency", 33'(n), 33'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("valid_held", 33'(valid_o[d]), 33'd1);
        end
        @(posedge clk);
        #1;
        yumi_i[d] = 1'b1;
        @(posedge clk);
        #1;
        yumi_i[d] = 1'b0;
        @(negedge clk);
        check("idle_after_yumi", {31'd0, busy_o[d], valid_o[d]}, 33'd0);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        n_reset         = 2'b00;
        valid_i         = 2'b01;
        wen_i           = '0;
        byte_not_word_i = '0;
        addr_i          = '0;
        write_data_i    = '0;
        yumi_i          = '0;

        // Reset state, with a request pending that must not be accepted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("yumi_in_reset", 33'(yumi_o[0]), 33'd0);
        check("reset_outs0", {err_o[0], read_data_o[0]}, 33'd0);
        check("reset_flags", {29'd0, valid_o, busy_o}, 33'd0);
        check("reset_outs1", {err_o[1], read_data_o[1]}, 33'd0);
        @(posedge clk);
        #1;
        valid_i = 2'b00;
        n_reset = 2'b11;

        // Latency 0: store then load, accept in the same cycle as valid_i.
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 33'h0, 1'b1, w);
        check("t1_store_yumi_same_cycle", 33'(w), 33'd0);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1, w);
        check("t1_load_yumi_same_cycle", 33'(w), 33'd0);
        wait_resp(0, 0, 0);

        // Byte lanes.
        issue(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 33'h0, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b1, 1'b1, 32'h13, 32'hFFFFFFAB, 33'h0, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hAB223344}, 1'b1, w);
        wait_resp(0, 1, 0);
        issue(0, 1'b0, 1'b1, 32'h12, 32'h0, {1'b0, 32'h00000022}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b1, 32'h11, 32'h0, {1'b0, 32'h00000033}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b1, 32'h13, 32'h0, {1'b0, 32'h000000AB}, 1'b1, w);
        wait_resp(0, 0, 0);

        // Address wrap: upper bits beyond the word index are ignored.
        issue(0, 1'b0, 1'b0, 32'h00001010, 32'h0, {1'b0, 32'hAB223344}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'hFFFFF010, 32'h0, {1'b0, 32'hAB223344}, 1'b1, w);
        wait_resp(0, 0, 0);

        // Misaligned word store.
`ifdef DMEM_MISALIGN_CHECK_EN
        issue(0, 1'b1, 1'b0, 32'h12, 32'hCAFEF00D, {1'b1, 32'h0}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hAB223344}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h12, 32'h0, {1'b1, 32'h0}, 1'b1, w);
        wait_resp(0, 0, 0);
`else
        issue(0, 1'b1, 1'b0, 32'h12, 32'hCAFEF00D, {1'b0, 32'h0}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1, w);
        wait_resp(0, 0, 0);
        issue(0, 1'b0, 1'b0, 32'h12, 32'h0, {1'b0, 32'hCAFEF00D}, 1'b1, w);
        wait_resp(0, 0, 0);
`endif

        // Latency 3, response held for 5 cycles.
        issue(1, 1'b1, 1'b0, 32'h20, 32'h01020304, 33'h0, 1'b1, w);
        wait_resp(1, 0, 3);
        issue(1, 1'b0, 1'b0, 32'h20, 32'h0, {1'b0, 32'h01020304}, 1'b1, w);
        check("t3_yumi_same_cycle", 33'(w), 33'd0);
        wait_resp(1, 5, 3);

        // valid_i held through WAIT/RESP: no accept until back in IDLE.
        @(posedge clk);
        #1;
        push_exp(1, {1'b0, 32'h01020304});
        wen_i[1] = 1'b0; byte_not_word_i[1] = 1'b0; addr_i[1] = 32'h20; valid_i[1] = 1'b1;
        @(negedge clk);
        check("t4_first_accept", 33'(yumi_o[1]), 33'd1);
        @(posedge clk);
        #1;
        push_exp(1, {1'b0, 32'h00000003});
        byte_not_word_i[1] = 1'b1; addr_i[1] = 32'h21;
        n = 0;
        forever begin
            @(negedge clk);
            check("t4_no_yumi_busy", 33'(yumi_o[1]), 33'd0);
            if (valid_o[1]) break;
            n++;
            if (n > 50) break;
        end
        check("t4_latency", 33'(n), 33'd3);
        @(posedge clk);
        #1;
        yumi_i[1] = 1'b1;
        @(negedge clk);
        check("t4_no_yumi_with_resp_yumi", 33'(yumi_o[1]), 33'd0);
        @(posedge clk);
        #1;
        yumi_i[1] = 1'b0;
        @(negedge clk);
        check("t4_accept_after_idle", 33'(yumi_o[1]), 33'd1);
        @(posedge clk);
        #1;
        valid_i[1] = 1'b0;
        wait_resp(1, 0, 3);

        // Reset during WAIT after a store: response aborted, store kept.
        issue(1, 1'b1, 1'b0, 32'h40, 32'h5A5A5A5A, 33'h0, 1'b0, w);
        @(negedge clk);
        check("t5_busy_in_wait", 33'(busy_o[1]), 33'd1);
        @(posedge clk);
        #1;
        n_reset[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_after_reset", {31'd0, valid_o[1], busy_o[1]}, 33'd0);
        @(posedge clk);
        #1;
        n_reset[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_resp", 33'(valid_o[1]), 33'd0);
        end
        issue(1, 1'b0, 1'b0, 32'h40, 32'h0, {1'b0, 32'h5A5A5A5A}, 1'b1, w);
        wait_resp(1, 0, 3);

        repeat (3) @(negedge clk);
        check("q0_drained", 33'(exp_q0.size()), 33'd0);
        check("q1_drained", 33'(exp_q1.size()), 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
